// File: rtl/pcie_rq_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_rq_arbiter
//   Packet-level 2:1 arbiter that shares the PCIe RQ AXI-stream between user
//   request traffic (port 0) and the ATS invalidation-completion generator
//   (port 1). A grant is held from a packet's first beat through tlast, so
//   TLPs are never interleaved. The output is a single register stage that
//   sustains one beat per clock.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   s0_axis_*           : user RQ stream (tdata/tkeep/tuser/tlast/tvalid/tready)
//   s1_axis_*           : ATS completion stream (no tuser)
//   m_axis_*            : registered stream towards the PCIe core RQ port
//   grant_port          : port that started the most recent packet
//   pkt_cnt0/pkt_cnt1   : completed packets per port, wrapping
//   starve_cnt          : consecutive packet starts lost by a waiting port 0
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// Sources may not retract tvalid or change a beat until it transfers.
// s*_axis_tready depend combinationally on the registered output state,
// m_axis_tready and the source tvalids; they are never asserted while the
// output register is full and stalled.
// ---------------------------------------------------------------------------
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int RQ_TUSER_WIDTH  = 137,
    parameter int ATS_PRIORITY    = 1,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
    input  logic [RQ_TUSER_WIDTH-1:0]    s0_axis_tuser,
    input  logic                         s0_axis_tlast,
    input  logic                         s0_axis_tvalid,
    output logic                         s0_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
    input  logic                         s1_axis_tlast,
    input  logic                         s1_axis_tvalid,
    output logic                         s1_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [RQ_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         grant_port,
    output logic [15:0]                  pkt_cnt0,
    output logic [15:0]                  pkt_cnt1,
    output logic [7:0]                   starve_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [AXIS_DATA_WIDTH-1:0]   r_m_tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] r_m_tkeep;
    logic [RQ_TUSER_WIDTH-1:0]    r_m_tuser;
    logic                         r_m_tlast;
    logic                         r_m_tvalid;
    logic                         r_grant_port;
    logic                         r_rr_next;      // port preferred on the next RR contention
    logic [15:0]                  r_pkt_cnt0;
    logic [15:0]                  r_pkt_cnt1;
    logic [7:0]                   r_starve_cnt;

    logic                         w_load;
    logic                         w_sel1;
    logic                         w_s0_ready;
    logic                         w_s1_ready;
    logic                         w_acc0;
    logic                         w_acc1;
    logic                         w_start;

    // The output register can take a new beat when it is empty or draining.
    assign w_load = !r_m_tvalid || m_axis_tready;

    // Winner selection, only meaningful in IDLE.
    always_comb begin
        w_sel1 = 1'b0;
        if (s1_axis_tvalid && !s0_axis_tvalid) begin
            w_sel1 = 1'b1;
        end else if (s1_axis_tvalid && s0_axis_tvalid) begin
            if (ATS_PRIORITY != 0) begin
                // ATS wins unless port 0 has lost too many starts in a row.
                w_sel1 = (r_starve_cnt != LIMIT);
            end else begin
                w_sel1 = r_rr_next;
            end
        end
    end

    // Next state and ready generation.
    always_comb begin
        w_state_nxt = r_state;
        w_s0_ready  = 1'b0;
        w_s1_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s0_ready = w_load && !w_sel1;
                w_s1_ready = w_load && w_sel1;
            end
            ST_LOCK0: w_s0_ready = w_load;
            ST_LOCK1: w_s1_ready = w_load;
            default:  w_state_nxt = ST_IDLE;
        endcase

        w_acc0 = s0_axis_tvalid && w_s0_ready;
        w_acc1 = s1_axis_tvalid && w_s1_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_acc0 && !s0_axis_tlast) begin
                    w_state_nxt = ST_LOCK0;
                end else if (w_acc1 && !s1_axis_tlast) begin
                    w_state_nxt = ST_LOCK1;
                end
            end
            ST_LOCK0: if (w_acc0 && s0_axis_tlast) w_state_nxt = ST_IDLE;
            ST_LOCK1: if (w_acc1 && s1_axis_tlast) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A packet starts with the first beat accepted in IDLE; w_acc1 then names the port.
    assign w_start = (r_state == ST_IDLE) && (w_acc0 || w_acc1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= w_acc0 || w_acc1;
            if (w_acc1) begin
                r_m_tdata <= s1_axis_tdata;
                r_m_tkeep <= s1_axis_tkeep;
                r_m_tuser <= '0;              // ATS completions carry no RQ sideband
                r_m_tlast <= s1_axis_tlast;
            end else if (w_acc0) begin
                r_m_tdata <= s0_axis_tdata;
                r_m_tkeep <= s0_axis_tkeep;
                r_m_tuser <= s0_axis_tuser;
                r_m_tlast <= s0_axis_tlast;
            end
        end
    end

    // Grant bookkeeping, counters and starvation tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_port <= 1'b0;
            r_rr_next    <= 1'b0;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_start) begin
                r_grant_port <= w_acc1;
                r_rr_next    <= !w_acc1;
                if (ATS_PRIORITY != 0) begin
                    if (!w_acc1) begin
                        r_starve_cnt <= '0;
                    end else if (s0_axis_tvalid && (r_starve_cnt != LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + 8'd1;
                    end
                end
            end
            if (w_acc0 && s0_axis_tlast) r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
            if (w_acc1 && s1_axis_tlast) r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
        end
    end

    assign s0_axis_tready = w_s0_ready;
    assign s1_axis_tready = w_s1_ready;
    assign m_axis_tdata   = r_m_tdata;
    assign m_axis_tkeep   = r_m_tkeep;
    assign m_axis_tuser   = r_m_tuser;
    assign m_axis_tlast   = r_m_tlast;
    assign m_axis_tvalid  = r_m_tvalid;
    assign grant_port     = r_grant_port;
    assign pkt_cnt0       = r_pkt_cnt0;
    assign pkt_cnt1       = r_pkt_cnt1;
    assign starve_cnt     = r_starve_cnt;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_rq_arbiter
//   Instance a: ATS_PRIORITY=1, STARVE_LIMIT=4 (directed packet scenarios).
//   Instance b: ATS_PRIORITY=0 (round-robin alternation).
//   Expected output beats are queued in hand-derived order; a monitor per
//   instance pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_pcie_rq_arbiter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 137;
  localparam int BW = DW + KW + UW + 1;

  logic clk;
  logic rst_n;

  logic [DW-1:0] a_s0_tdata, a_s1_tdata, a_m_tdata;
  logic [KW-1:0] a_s0_tkeep, a_s1_tkeep, a_m_tkeep;
  logic [UW-1:0] a_s0_tuser, a_m_tuser;
  logic          a_s0_tlast, a_s0_tvalid, a_s0_tready;
  logic          a_s1_tlast, a_s1_tvalid, a_s1_tready;
  logic          a_m_tlast, a_m_tvalid, a_m_tready;
  logic          a_grant_port;
  logic [15:0]   a_pkt_cnt0, a_pkt_cnt1;
  logic [7:0]    a_starve_cnt;

  logic [DW-1:0] b_s0_tdata, b_s1_tdata, b_m_tdata;
  logic [KW-1:0] b_s0_tkeep, b_s1_tkeep, b_m_tkeep;
  logic [UW-1:0] b_s0_tuser, b_m_tuser;
  logic          b_s0_tlast, b_s0_tvalid, b_s0_tready;
  logic          b_s1_tlast, b_s1_tvalid, b_s1_tready;
  logic          b_m_tlast, b_m_tvalid, b_m_tready;
  logic          b_grant_port;
  logic [15:0]   b_pkt_cnt0, b_pkt_cnt1;
  logic [7:0]    b_starve_cnt;

  logic [BW-1:0] exp_a[$];
  logic [BW-1:0] exp_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  pcie_rq_arbiter #(
    .AXIS_DATA_WIDTH(DW), .RQ_TUSER_WIDTH(UW), .ATS_PRIORITY(1), .STARVE_LIMIT(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(a_s0_tdata), .s0_axis_tkeep(a_s0_tkeep), .s0_axis_tuser(a_s0_tuser),
    .s0_axis_tlast(a_s0_tlast), .s0_axis_tvalid(a_s0_tvalid), .s0_axis_tready(a_s0_tready),
    .s1_axis_tdata(a_s1_tdata), .s1_axis_tkeep(a_s1_tkeep),
    .s1_axis_tlast(a_s1_tlast), .s1_axis_tvalid(a_s1_tvalid), .s1_axis_tready(a_s1_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tuser(a_m_tuser),
    .m_axis_tlast(a_m_tlast), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .grant_port(a_grant_port), .pkt_cnt0(a_pkt_cnt0), .pkt_cnt1(a_pkt_cnt1),
    .starve_cnt(a_starve_cnt)
  );

  pcie_rq_arbiter #(
    .AXIS_DATA_WIDTH(DW), .RQ_TUSER_WIDTH(UW), .ATS_PRIORITY(0), .STARVE_LIMIT(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(b_s0_tdata), .s0_axis_tkeep(b_s0_tkeep), .s0_axis_tuser(b_s0_tuser),
    .s0_axis_tlast(b_s0_tlast), .s0_axis_tvalid(b_s0_tvalid), .s0_axis_tready(b_s0_tready),
    .s1_axis_tdata(b_s1_tdata), .s1_axis_tkeep(b_s1_tkeep),
    .s1_axis_tlast(b_s1_tlast), .s1_axis_tvalid(b_s1_tvalid), .s1_axis_tready(b_s1_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tuser(b_m_tuser),
    .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .grant_port(b_grant_port), .pkt_cnt0(b_pkt_cnt0), .pkt_cnt1(b_pkt_cnt1),
    .starve_cnt(b_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- beat patterns ----------------
  function automatic logic [DW-1:0] mk_data(input int port, input int seq);
    logic [DW-1:0] d;
    d = '0;
    d[31:0]    = 32'(seq);
    d[39:32]   = 8'(port);
    d[111:104] = (port == 1) ? 8'h30 : 8'h00;
    d[511:480] = 32'hA5A5_0000 | 32'(seq);
    return d;
  endfunction

  function automatic logic [KW-1:0] mk_keep(input logic last);
    return last ? {{16{1'b0}}, {48{1'b1}}} : {KW{1'b1}};
  endfunction

  function automatic logic [UW-1:0] mk_user(input int seq);
    logic [UW-1:0] u;
    u = '0;
    u[63:0]    = 64'h0123_4567_0000_0000 | 64'(seq);
    u[136:128] = 9'h1A5;
    return u;
  endfunction

  // Expected output beat: port-1 beats must leave with tuser cleared.
  function automatic logic [BW-1:0] exp_beat(input int port, input int seq, input logic last);
    logic [UW-1:0] u;
    u = (port == 1) ? '0 : mk_user(seq);
    return {mk_data(port, seq), mk_keep(last), u, last};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- drivers (instance a) ----------------
  task automatic drive_s0(input int first_seq, input int npkt, input int nbeats);
    int  cnt;
    int  seq;
    logic ok;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < nbeats; b++) begin
        seq         = first_seq + p * nbeats + b;
        a_s0_tdata  = mk_data(0, seq);
        a_s0_tlast  = (b == nbeats - 1);
        a_s0_tkeep  = mk_keep(a_s0_tlast);
        a_s0_tuser  = mk_user(seq);
        a_s0_tvalid = 1'b1;
        cnt = 0;
        do begin
          @(negedge clk);
          ok = a_s0_tready;
          @(posedge clk);
          #1;
          cnt++;
        end while (!ok && cnt < 200);
        if (!ok) begin
          n_checks++;
          $display("FAIL s0_timeout: seq %0d never accepted", seq);
        end
      end
    end
    a_s0_tvalid = 1'b0;
  endtask

  task automatic drive_s1(input int first_seq, input int npkt, input int nbeats);
    int  cnt;
    int  seq;
    logic ok;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < nbeats; b++) begin
        seq         = first_seq + p * nbeats + b;
        a_s1_tdata  = mk_data(1, seq);
        a_s1_tlast  = (b == nbeats - 1);
        a_s1_tkeep  = mk_keep(a_s1_tlast);
        a_s1_tvalid = 1'b1;
        cnt = 0;
        do begin
          @(negedge clk);
          ok = a_s1_tready;
          @(posedge clk);
          #1;
          cnt++;
        end while (!ok && cnt < 200);
        if (!ok) begin
          n_checks++;
          $display("FAIL s1_timeout: seq %0d never accepted", seq);
        end
      end
    end
    a_s1_tvalid = 1'b0;
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin : mon_a
    logic [BW-1:0] act;
    logic [BW-1:0] req;
    if (a_m_tvalid && a_m_tready) begin
      act = {a_m_tdata, a_m_tkeep, a_m_tuser, a_m_tlast};
      n_checks++;
      if (exp_a.size() == 0) begin
        $display("FAIL a_out_beat: unexpected beat data[31:0]=%0h", a_m_tdata[31:0]);
      end else begin
        req = exp_a.pop_front();
        if (act === req) n_pass++;
        else $display("FAIL a_out_beat: got %h expected %h", act, req);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [BW-1:0] act;
    logic [BW-1:0] req;
    if (b_m_tvalid && b_m_tready) begin
      act = {b_m_tdata, b_m_tkeep, b_m_tuser, b_m_tlast};
      n_checks++;
      if (exp_b.size() == 0) begin
        $display("FAIL b_out_beat: unexpected beat data[39:0]=%0h", b_m_tdata[39:0]);
      end else begin
        req = exp_b.pop_front();
        if (act === req) n_pass++;
        else $display("FAIL b_out_beat: got %h expected %h", act, req);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int r_max;
    rst_n = 1'b0;
    a_s0_tdata = '0; a_s0_tkeep = '0; a_s0_tuser = '0; a_s0_tlast = 1'b0; a_s0_tvalid = 1'b0;
    a_s1_tdata = '0; a_s1_tkeep = '0; a_s1_tlast = 1'b0; a_s1_tvalid = 1'b0;
    b_s0_tdata = '0; b_s0_tkeep = '0; b_s0_tuser = '0; b_s0_tlast = 1'b0; b_s0_tvalid = 1'b0;
    b_s1_tdata = '0; b_s1_tkeep = '0; b_s1_tlast = 1'b0; b_s1_tvalid = 1'b0;
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;

    // Reset values
    wait_cyc(3);
    check("rst_m_tvalid", 64'(a_m_tvalid), 64'd0);
    check("rst_m_tdata", a_m_tdata[63:0], 64'd0);
    check("rst_grant_port", 64'(a_grant_port), 64'd0);
    check("rst_pkt_cnt0", 64'(a_pkt_cnt0), 64'd0);
    check("rst_pkt_cnt1", 64'(a_pkt_cnt1), 64'd0);
    check("rst_starve_cnt", 64'(a_starve_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);

    // Round robin (instance b): both always valid, strict alternation from port 0
    b_s0_tdata = mk_data(0, 50); b_s0_tlast = 1'b1; b_s0_tkeep = mk_keep(1'b1);
    b_s0_tuser = mk_user(50);
    b_s1_tdata = mk_data(1, 60); b_s1_tlast = 1'b1; b_s1_tkeep = mk_keep(1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back(exp_beat(0, 50, 1'b1));
      exp_b.push_back(exp_beat(1, 60, 1'b1));
    end
    b_s0_tvalid = 1'b1;
    b_s1_tvalid = 1'b1;
    wait_cyc(8);
    b_s0_tvalid = 1'b0;
    b_s1_tvalid = 1'b0;
    wait_cyc(2);
    check("rr_pkt_cnt0", 64'(b_pkt_cnt0), 64'd4);
    check("rr_pkt_cnt1", 64'(b_pkt_cnt1), 64'd4);
    check("rr_starve_cnt", 64'(b_starve_cnt), 64'd0);
    check("rr_grant_port", 64'(b_grant_port), 64'd1);
    check("rr_m_tvalid_idle", 64'(b_m_tvalid), 64'd0);

    // Single-beat ATS completion, port 0 idle
    exp_a.push_back(exp_beat(1, 1, 1'b1));
    drive_s1(1, 1, 1);
    check("t1_latency_tvalid", 64'(a_m_tvalid), 64'd1);
    check("t1_tag_111_104", 64'(a_m_tdata[111:104]), 64'h30);
    wait_cyc(1);
    check("t1_pkt_cnt1", 64'(a_pkt_cnt1), 64'd1);
    check("t1_grant_port", 64'(a_grant_port), 64'd1);
    check("t1_starve_cnt", 64'(a_starve_cnt), 64'd0);
    check("t1_tvalid_drop", 64'(a_m_tvalid), 64'd0);

    // Port-0 4-beat packet, port 1 arrives at beat 2 and must wait
    for (int b = 0; b < 4; b++) exp_a.push_back(exp_beat(0, 10 + b, b == 3));
    exp_a.push_back(exp_beat(1, 20, 1'b1));
    fork
      drive_s0(10, 1, 4);
      begin
        wait_cyc(1);
        drive_s1(20, 1, 1);
      end
    join
    wait_cyc(2);
    check("t2_pkt_cnt0", 64'(a_pkt_cnt0), 64'd1);
    check("t2_pkt_cnt1", 64'(a_pkt_cnt1), 64'd2);
    check("t2_grant_port", 64'(a_grant_port), 64'd1);

    // Starvation limit: order 1,1,1,1,0,1,1,1,1,0
    for (int i = 0; i < 4; i++) exp_a.push_back(exp_beat(1, 200 + i, 1'b1));
    exp_a.push_back(exp_beat(0, 100, 1'b1));
    for (int i = 4; i < 8; i++) exp_a.push_back(exp_beat(1, 200 + i, 1'b1));
    exp_a.push_back(exp_beat(0, 101, 1'b1));
    r_max = 0;
    fork
      drive_s0(100, 2, 1);
      drive_s1(200, 8, 1);
      begin
        repeat (20) begin
          @(negedge clk);
          if (int'(a_starve_cnt) > r_max) r_max = int'(a_starve_cnt);
        end
      end
    join
    wait_cyc(1);
    check("t3_starve_max", 64'(r_max), 64'd4);
    check("t3_starve_cleared", 64'(a_starve_cnt), 64'd0);
    check("t3_pkt_cnt0", 64'(a_pkt_cnt0), 64'd3);
    check("t3_pkt_cnt1", 64'(a_pkt_cnt1), 64'd10);
    check("t3_grant_port", 64'(a_grant_port), 64'd0);

    // Output stall for 5 cycles mid-packet
    for (int b = 0; b < 4; b++) exp_a.push_back(exp_beat(0, 300 + b, b == 3));
    fork
      drive_s0(300, 1, 4);
      begin
        wait_cyc(2);
        a_m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t4_stall_tvalid", 64'(a_m_tvalid), 64'd1);
          check("t4_stall_data", 64'(a_m_tdata[31:0]), 64'd301);
          check("t4_stall_s0_tready", 64'(a_s0_tready), 64'd0);
          check("t4_stall_s1_tready", 64'(a_s1_tready), 64'd0);
          @(posedge clk);
        end
        #1;
        a_m_tready = 1'b1;
      end
    join
    wait_cyc(2);
    check("t4_pkt_cnt0", 64'(a_pkt_cnt0), 64'd4);

    // Reset during a locked port-0 packet
    exp_a.push_back(exp_beat(0, 400, 1'b0));
    a_s0_tdata = mk_data(0, 400); a_s0_tlast = 1'b0; a_s0_tkeep = mk_keep(1'b0);
    a_s0_tuser = mk_user(400); a_s0_tvalid = 1'b1;
    wait_cyc(1);
    a_s0_tdata = mk_data(0, 401); a_s0_tuser = mk_user(401);
    wait_cyc(1);
    rst_n = 1'b0;
    a_s0_tvalid = 1'b0;
    #1;
    check("t5_rst_tvalid", 64'(a_m_tvalid), 64'd0);
    check("t5_rst_pkt_cnt0", 64'(a_pkt_cnt0), 64'd0);
    check("t5_rst_pkt_cnt1", 64'(a_pkt_cnt1), 64'd0);
    check("t5_rst_starve", 64'(a_starve_cnt), 64'd0);
    check("t5_rst_grant", 64'(a_grant_port), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);
    exp_a.push_back(exp_beat(1, 500, 1'b1));
    drive_s1(500, 1, 1);
    wait_cyc(1);
    check("t5_grant_port", 64'(a_grant_port), 64'd1);
    check("t5_pkt_cnt1", 64'(a_pkt_cnt1), 64'd1);
    check("t5_pkt_cnt0", 64'(a_pkt_cnt0), 64'd0);

    // Drain and close
    for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(posedge clk);
    check("exp_a_empty", 64'(exp_a.size()), 64'd0);
    check("exp_b_empty", 64'(exp_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
